// File: rtl/tile_checker.sv
// tile_checker: scores player guesses against a latched lit-tile board.
// The FSM states are IDLE, PLAY, WIN and LOSE. Each accepted guess gives a
// registered result one cycle later, together with updated counters and the
// revealed mask.
// Optional feature: define TILE_CHECKER_TIMEOUT_EN to add an inactivity timer.
// With it, TIMEOUT_CYCLES idle cycles in PLAY end the round as lost.
module tile_checker #(
   parameter int TILES    = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_MISS = 3
`ifdef TILE_CHECKER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             board_load,
   input  logic [TILES-1:0] board_in,
   input  logic             guess_valid,
   input  logic [IDX_W-1:0] guess_idx,
   output logic             guess_ready,
   output logic             result_valid,
   output logic             result_hit,
   output logic             result_dup,
   output logic [TILES-1:0] revealed,
   output logic [4:0]       hit_count,
   output logic [3:0]       miss_count,
   output logic             won,
   output logic             lost
);

   typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

   localparam logic [3:0] MAX_MISS_C = 4'(MAX_MISS);

   state_t           state_reg, state_next;
   logic [TILES-1:0] board_reg, board_next;
   logic [TILES-1:0] revealed_reg, revealed_next;
   logic [4:0]       hit_count_reg, hit_count_next;
   logic [3:0]       miss_count_reg, miss_count_next;
   logic             result_valid_reg, result_valid_next;
   logic             result_hit_reg, result_hit_next;
   logic             result_dup_reg, result_dup_next;

   logic [TILES-1:0] guess_onehot;
   logic             guess_accept;
   logic             guess_lit;
   logic             guess_dup;

`ifdef TILE_CHECKER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   logic [TMR_W-1:0] timer_reg, timer_next;
`endif

   // Decode the guess into a one-hot tile mask.
   // An index outside the board decodes to all zeros, so it scores as a miss.
   genvar gi;
   generate
      for (gi = 0; gi < TILES; gi++) begin : g_decode
         assign guess_onehot[gi] = (guess_idx == IDX_W'(gi));
      end
   endgenerate

   // A coincident board_load wins over a guess, so the guess is not accepted.
   assign guess_accept = guess_valid && (state_reg == PLAY) && !board_load;
   assign guess_lit    = |(guess_onehot & board_reg);
   assign guess_dup    = |(guess_onehot & revealed_reg);

   // Next-state and datapath update: a load first, then the accepted guess, then the timeout.
   always_comb begin
      state_next        = state_reg;
      board_next        = board_reg;
      revealed_next     = revealed_reg;
      hit_count_next    = hit_count_reg;
      miss_count_next   = miss_count_reg;
      result_valid_next = 1'b0;
      result_hit_next   = 1'b0;
      result_dup_next   = 1'b0;
`ifdef TILE_CHECKER_TIMEOUT_EN
      timer_next        = (state_reg == PLAY) ? timer_reg + 1'b1 : '0;
`endif
      if (board_load) begin
         board_next      = board_in;
         revealed_next   = '0;
         hit_count_next  = '0;
         miss_count_next = '0;
         state_next      = (board_in == '0) ? WIN : PLAY;
`ifdef TILE_CHECKER_TIMEOUT_EN
         timer_next      = '0;
`endif
      end else if (guess_accept) begin
         result_valid_next = 1'b1;
`ifdef TILE_CHECKER_TIMEOUT_EN
         timer_next        = '0;
`endif
         if (guess_dup) begin
            result_dup_next = 1'b1;
         end else if (guess_lit) begin
            result_hit_next = 1'b1;
            revealed_next   = revealed_reg | guess_onehot;
            hit_count_next  = hit_count_reg + 5'd1;
            if (revealed_next == board_reg) begin
               state_next = WIN;
            end
         end else begin
            miss_count_next = miss_count_reg + 4'd1;
            if (miss_count_next == MAX_MISS_C) begin
               state_next = LOSE;
            end
         end
`ifdef TILE_CHECKER_TIMEOUT_EN
      end else if ((state_reg == PLAY) && (timer_reg == TMR_LAST)) begin
         state_next = LOSE;
`endif
      end
   end

   // State and datapath registers; an active-low reset drops any pending result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg        <= IDLE;
         board_reg        <= '0;
         revealed_reg     <= '0;
         hit_count_reg    <= '0;
         miss_count_reg   <= '0;
         result_valid_reg <= 1'b0;
         result_hit_reg   <= 1'b0;
         result_dup_reg   <= 1'b0;
`ifdef TILE_CHECKER_TIMEOUT_EN
         timer_reg        <= '0;
`endif
      end else begin
         state_reg        <= state_next;
         board_reg        <= board_next;
         revealed_reg     <= revealed_next;
         hit_count_reg    <= hit_count_next;
         miss_count_reg   <= miss_count_next;
         result_valid_reg <= result_valid_next;
         result_hit_reg   <= result_hit_next;
         result_dup_reg   <= result_dup_next;
`ifdef TILE_CHECKER_TIMEOUT_EN
         timer_reg        <= timer_next;
`endif
      end
   end

   assign guess_ready  = (state_reg == PLAY);
   assign result_valid = result_valid_reg;
   assign result_hit   = result_hit_reg;
   assign result_dup   = result_dup_reg;
   assign revealed     = revealed_reg;
   assign hit_count    = hit_count_reg;
   assign miss_count   = miss_count_reg;
   assign won          = (state_reg == WIN);
   assign lost         = (state_reg == LOSE);

endmodule

// File: tb/tb_tile_checker.sv
// tb_tile_checker: directed game sequences with hand-computed expectations.
// Expected results are queued when a guess is issued. A negedge monitor then
// pops and compares them whenever result_valid is seen.
module tb_tile_checker;

   localparam int TILES    = 16;
   localparam int IDX_W    = 4;
   localparam int MAX_MISS = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             board_load = 1'b0;
   logic [TILES-1:0] board_in = '0;
   logic             guess_valid = 1'b0;
   logic [IDX_W-1:0] guess_idx = '0;
   logic             guess_ready;
   logic             result_valid;
   logic             result_hit;
   logic             result_dup;
   logic [TILES-1:0] revealed;
   logic [4:0]       hit_count;
   logic [3:0]       miss_count;
   logic             won;
   logic             lost;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic        hit;
      logic        dup;
      logic [4:0]  hc;
      logic [3:0]  mc;
      logic        won;
      logic        lost;
      logic [15:0] rev;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

`ifdef TILE_CHECKER_TIMEOUT_EN
   tile_checker #(.TILES(TILES), .IDX_W(IDX_W), .MAX_MISS(MAX_MISS), .TIMEOUT_CYCLES(10)) dut (
`else
   tile_checker #(.TILES(TILES), .IDX_W(IDX_W), .MAX_MISS(MAX_MISS)) dut (
`endif
      .clk(clk), .reset(reset), .board_load(board_load), .board_in(board_in),
      .guess_valid(guess_valid), .guess_idx(guess_idx), .guess_ready(guess_ready),
      .result_valid(result_valid), .result_hit(result_hit), .result_dup(result_dup),
      .revealed(revealed), .hit_count(hit_count), .miss_count(miss_count),
      .won(won), .lost(lost));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every result pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_hit", 32'(result_hit), 32'(e.hit));
            chk("result_dup", 32'(result_dup), 32'(e.dup));
            chk("hit_count", 32'(hit_count), 32'(e.hc));
            chk("miss_count", 32'(miss_count), 32'(e.mc));
            chk("won", 32'(won), 32'(e.won));
            chk("lost", 32'(lost), 32'(e.lost));
            chk("revealed", 32'(revealed), 32'(e.rev));
            checks++;
            if (hit_count > 5'(TILES) || miss_count > 4'(MAX_MISS)) begin
               fails++;
               $display("FAIL counter_saturation: hit_count %0d miss_count %0d", hit_count, miss_count);
            end
            $display("result: hit=%0d dup=%0d hc=%0d mc=%0d won=%0d lost=%0d rev=%h",
                     result_hit, result_dup, hit_count, miss_count, won, lost, revealed);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] pat);
      board_load = 1'b1;
      board_in   = pat;
      tick();
      board_load = 1'b0;
      $display("load board %h", pat);
   endtask

   // Issue one guess and queue the expected response.
   task automatic guess(input int idx, input logic hit, input logic dup, input int hc,
                        input int mc, input logic w, input logic l, input logic [15:0] rev);
      exp_t e;
      e.hit = hit; e.dup = dup; e.hc = 5'(hc); e.mc = 4'(mc);
      e.won = w; e.lost = l; e.rev = rev;
      exp_q.push_back(e);
      guess_valid = 1'b1;
      guess_idx   = IDX_W'(idx);
      tick();
      guess_valid = 1'b0;
      $display("guess tile %0d", idx);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (3) tick();
      chk("rst_guess_ready", 32'(guess_ready), 0);
      chk("rst_result_valid", 32'(result_valid), 0);
      chk("rst_revealed", 32'(revealed), 0);
      chk("rst_counts", {hit_count, miss_count}, 0);
      chk("rst_won_lost", {won, lost}, 0);
      reset = 1'b1;
      tick();
      guess_valid = 1'b1; guess_idx = 4'd0;   // ignored in IDLE
      tick();
      guess_valid = 1'b0;
      chk("idle_ignores_guess", 32'(result_valid), 0);

      // Single lit tile: one hit wins.
      load(16'h0001);
      chk("play_ready", 32'(guess_ready), 1);
      guess(0, 1, 0, 1, 0, 1, 0, 16'h0001);
      tick();
      chk("win_ready_low", 32'(guess_ready), 0);

      // Three misses lose; a fourth guess is ignored.
      load(16'h00F0);
      guess(0, 0, 0, 0, 1, 0, 0, 16'h0000);
      guess(1, 0, 0, 0, 2, 0, 0, 16'h0000);
      guess(2, 0, 0, 0, 3, 0, 1, 16'h0000);
      guess_valid = 1'b1; guess_idx = 4'd3;
      tick();
      guess_valid = 1'b0;
      chk("lose_no_result", 32'(result_valid), 0);
      chk("lose_miss_hold", 32'(miss_count), 3);
      chk("lose_hold", 32'(lost), 1);

      // A duplicate guess leaves the counters alone.
      load(16'h0030);
      guess(4, 1, 0, 1, 0, 0, 0, 16'h0010);
      guess(4, 0, 1, 1, 0, 0, 0, 16'h0010);
      guess(5, 1, 0, 2, 0, 1, 0, 16'h0030);

      // Highest tile index, and the unlit tile next to it.
      load(16'h8003);
      guess(15, 1, 0, 1, 0, 0, 0, 16'h8000);
      guess(14, 0, 0, 1, 1, 0, 0, 16'h8000);

      // A load coincident with a guess wins; the guess is dropped.
      load(16'h00F0);
      guess(4, 1, 0, 1, 0, 0, 0, 16'h0010);
      board_load = 1'b1; board_in = 16'h0300;
      guess_valid = 1'b1; guess_idx = 4'd5;
      tick();
      board_load = 1'b0; guess_valid = 1'b0;
      chk("coinc_no_result", 32'(result_valid), 0);
      chk("coinc_counts", {hit_count, miss_count}, 0);
      chk("coinc_revealed", 32'(revealed), 0);
      guess(8, 1, 0, 1, 0, 0, 0, 16'h0100);
      guess(4, 0, 0, 1, 1, 0, 0, 16'h0100);

      // An empty board wins immediately.
      load(16'h0000);
      chk("empty_won", 32'(won), 1);
      chk("empty_ready", 32'(guess_ready), 0);

      // Reset coincident with an accepted guess drops the result.
      load(16'h00F0);
      guess_valid = 1'b1; guess_idx = 4'd4;
      reset = 1'b0;
      tick();
      guess_valid = 1'b0;
      chk("rst_drop_valid", 32'(result_valid), 0);
      chk("rst_drop_state", {guess_ready, won, lost}, 0);
      chk("rst_drop_regs", {revealed, hit_count, miss_count}, 0);
      reset = 1'b1;
      tick();
      chk("rst_drop_after", 32'(result_valid), 0);

      // Inactivity in PLAY.
      load(16'h00F0);
`ifdef TILE_CHECKER_TIMEOUT_EN
      repeat (12) tick();
      chk("timeout_lost", 32'(lost), 1);
`else
      repeat (20) tick();
      chk("no_timeout_lost", 32'(lost), 0);
      chk("no_timeout_ready", 32'(guess_ready), 1);
`endif

      tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
